vmem_wr_arbiter: RTL and testbench

//  Write-side controller for the VGA framebuffer (vmem, {h,v} addressed, 24-bit RGB).

---
 rtl/vmem_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_vmem_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_wr_arbiter.sv
// Framebuffer write-port controller: round-robin arbitration between two pixel
// requesters plus a full-frame fill engine, with a registered vmem write port.
module vmem_wr_arbiter #(
  parameter int H_W   = 10,
  parameter int V_W   = 9,
  parameter int DW    = 24,
  parameter int H_MAX = 640,
  parameter int V_MAX = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fill_start,
  input  logic [DW-1:0]  fill_color,
  output logic           fill_busy,
  output logic           fill_done,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [H_W-1:0] r0_h,
  input  logic [V_W-1:0] r0_v,
  input  logic [DW-1:0]  r0_data,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [H_W-1:0] r1_h,
  input  logic [V_W-1:0] r1_v,
  input  logic [DW-1:0]  r1_data,
  output logic           mem_we,
  output logic [H_W-1:0] mem_h,
  output logic [V_W-1:0] mem_v,
  output logic [DW-1:0]  mem_data,
  output logic           oob_err
);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_MAX - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_MAX - 1);
  localparam logic [H_W:0]   H_LIM  = (H_W + 1)'(H_MAX);
  localparam logic [V_W:0]   V_LIM  = (V_W + 1)'(V_MAX);

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state, state_nxt;
  logic           rr_ptr;
  logic [H_W-1:0] fill_h;
  logic [V_W-1:0] fill_v;
  logic [DW-1:0]  fill_col;
  logic           fill_last;
  logic           arb_en;
  logic           hs0, hs1, hs_any;
  logic [H_W-1:0] wr_h_p0;
  logic [V_W-1:0] wr_v_p0;
  logic [DW-1:0]  wr_data_p0;
  logic           wr_oob_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign fill_last = (fill_h == H_LAST) && (fill_v == V_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = FILL;
      FILL:    if (fill_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rr_ptr names the requester that wins the next tie
  always_comb begin
    fill_busy = (state == FILL);
    arb_en    = (state == IDLE) && !fill_start;
    r0_ready  = arb_en && r0_valid && (!r1_valid || !rr_ptr);
    r1_ready  = arb_en && r1_valid && (!r0_valid ||  rr_ptr);
  end

  // Stage p0: select the granted request and range-check it
  assign hs0        = r0_valid && r0_ready;
  assign hs1        = r1_valid && r1_ready;
  assign hs_any     = hs0 || hs1;
  assign wr_h_p0    = hs1 ? r1_h    : r0_h;
  assign wr_v_p0    = hs1 ? r1_v    : r0_v;
  assign wr_data_p0 = hs1 ? r1_data : r0_data;
  assign wr_oob_p0  = ({1'b0, wr_h_p0} >= H_LIM) || ({1'b0, wr_v_p0} >= V_LIM);

  // Stage p1: registered write port, fill engine and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      fill_h    <= '0;
      fill_v    <= '0;
      fill_col  <= '0;
      fill_done <= 1'b0;
      oob_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_h     <= '0;
      mem_v     <= '0;
      mem_data  <= '0;
    end else begin
      fill_done <= 1'b0;
      mem_we    <= 1'b0;
      if (state == IDLE && fill_start) begin
        fill_h   <= '0;
        fill_v   <= '0;
        fill_col <= fill_color;
      end
      if (state == FILL) begin
        mem_we    <= 1'b1;
        mem_h     <= fill_h;
        mem_v     <= fill_v;
        mem_data  <= fill_col;
        fill_done <= fill_last;
        if (fill_h == H_LAST) begin
          fill_h <= '0;
          fill_v <= fill_v + 1'b1;
        end else begin
          fill_h <= fill_h + 1'b1;
        end
      end else if (hs_any) begin
        rr_ptr <= hs0;
        if (wr_oob_p0) begin
          oob_err <= 1'b1;
        end else begin
          mem_we   <= 1'b1;
          mem_h    <= wr_h_p0;
          mem_v    <= wr_v_p0;
          mem_data <= wr_data_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vmem_wr_arbiter.sv
// Directed bench: vector table for arbitration/latency on a default-size instance,
// hand sequences for reset, range check and fills on a 4x3 instance.
module tb_vmem_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default-size instance
  logic        fill_start, fill_busy, fill_done;
  logic [23:0] fill_color;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [9:0]  r0_h, r1_h, mem_h;
  logic [8:0]  r0_v, r1_v, mem_v;
  logic [23:0] r0_data, r1_data, mem_data;
  logic        mem_we, oob_err;

  // 4x3 instance
  logic        s_fill_start, s_fill_busy, s_fill_done;
  logic [23:0] s_fill_color;
  logic        s_r0_valid, s_r0_ready, s_r1_valid, s_r1_ready;
  logic [9:0]  s_r0_h, s_r1_h, s_mem_h;
  logic [8:0]  s_r0_v, s_r1_v, s_mem_v;
  logic [23:0] s_r0_data, s_r1_data, s_mem_data;
  logic        s_mem_we, s_oob_err;

  vmem_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_h(r0_h), .r0_v(r0_v), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_h(r1_h), .r1_v(r1_v), .r1_data(r1_data),
    .mem_we(mem_we), .mem_h(mem_h), .mem_v(mem_v), .mem_data(mem_data),
    .oob_err(oob_err)
  );

  vmem_wr_arbiter #(.H_MAX(4), .V_MAX(3)) dut_s (
    .clk(clk), .rst(rst),
    .fill_start(s_fill_start), .fill_color(s_fill_color),
    .fill_busy(s_fill_busy), .fill_done(s_fill_done),
    .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_h(s_r0_h), .r0_v(s_r0_v), .r0_data(s_r0_data),
    .r1_valid(s_r1_valid), .r1_ready(s_r1_ready), .r1_h(s_r1_h), .r1_v(s_r1_v), .r1_data(s_r1_data),
    .mem_we(s_mem_we), .mem_h(s_mem_h), .mem_v(s_mem_v), .mem_data(s_mem_data),
    .oob_err(s_oob_err)
  );

  typedef struct {
    logic        v0;
    logic [9:0]  h0;
    logic [8:0]  y0;
    logic [23:0] d0;
    logic        v1;
    logic [9:0]  h1;
    logic [8:0]  y1;
    logic [23:0] d1;
    logic        rdy0;
    logic        rdy1;
    logic        we;
    logic [9:0]  eh;
    logic [8:0]  ey;
    logic [23:0] ed;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    fill_start = 0; fill_color = 0;
    r0_valid = 0; r0_h = 0; r0_v = 0; r0_data = 0;
    r1_valid = 0; r1_h = 0; r1_v = 0; r1_data = 0;
    s_fill_start = 0; s_fill_color = 0;
    s_r0_valid = 0; s_r0_h = 0; s_r0_v = 0; s_r0_data = 0;
    s_r1_valid = 0; s_r1_h = 0; s_r1_v = 0; s_r1_data = 0;

    //          v0  h0   y0   d0          v1  h1   y1   d1          r0 r1 we  eh   ey   ed
    vec[0] = '{1, 10'd1,  9'd2,  24'h000011, 1, 10'd3,   9'd4,   24'h000022, 1, 0, 1, 10'd1,   9'd2,   24'h000011};
    vec[1] = '{1, 10'd5,  9'd6,  24'h000033, 1, 10'd3,   9'd4,   24'h000022, 0, 1, 1, 10'd3,   9'd4,   24'h000022};
    vec[2] = '{1, 10'd5,  9'd6,  24'h000033, 1, 10'd7,   9'd8,   24'h000044, 1, 0, 1, 10'd5,   9'd6,   24'h000033};
    vec[3] = '{1, 10'd9,  9'd10, 24'h000055, 1, 10'd7,   9'd8,   24'h000044, 0, 1, 1, 10'd7,   9'd8,   24'h000044};
    vec[4] = '{1, 10'd5,  9'd7,  24'hFF0000, 0, 10'd0,   9'd0,   24'h000000, 1, 0, 1, 10'd5,   9'd7,   24'hFF0000};
    vec[5] = '{0, 10'd0,  9'd0,  24'h000000, 0, 10'd0,   9'd0,   24'h000000, 0, 0, 0, 10'd5,   9'd7,   24'hFF0000};
    vec[6] = '{0, 10'd0,  9'd0,  24'h000000, 1, 10'd639, 9'd479, 24'hABCDEF, 0, 1, 1, 10'd639, 9'd479, 24'hABCDEF};
    vec[7] = '{1, 10'd0,  9'd0,  24'h123456, 0, 10'd0,   9'd0,   24'h000000, 1, 0, 1, 10'd0,   9'd0,   24'h123456};
    vec[8] = '{1, 10'd10, 9'd20, 24'h000001, 1, 10'd30,  9'd40,  24'h000002, 0, 1, 1, 10'd30,  9'd40,  24'h000002};
    vec[9] = '{1, 10'd11, 9'd21, 24'h000003, 1, 10'd31,  9'd41,  24'h000004, 1, 0, 1, 10'd11,  9'd21,  24'h000003};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_h", mem_h, 0);
    chk("rst_mem_v", mem_v, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_oob_err", oob_err, 0);
    @(negedge clk); rst = 0;

    // arbitration / latency table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r0_valid = vec[i].v0; r0_h = vec[i].h0; r0_v = vec[i].y0; r0_data = vec[i].d0;
      r1_valid = vec[i].v1; r1_h = vec[i].h1; r1_v = vec[i].y1; r1_data = vec[i].d1;
      #1;
      chk($sformatf("v%0d_r0_ready", i), r0_ready, vec[i].rdy0);
      chk($sformatf("v%0d_r1_ready", i), r1_ready, vec[i].rdy1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_we", i), mem_we, vec[i].we);
      chk($sformatf("v%0d_mem_h", i), mem_h, vec[i].eh);
      chk($sformatf("v%0d_mem_v", i), mem_v, vec[i].ey);
      chk($sformatf("v%0d_mem_data", i), mem_data, vec[i].ed);
    end
    @(negedge clk); r0_valid = 0; r1_valid = 0;

    // out-of-range request is accepted and dropped
    @(negedge clk);
    r1_valid = 1; r1_h = 10'd640; r1_v = 9'd0; r1_data = 24'h777777;
    #1;
    chk("oob_r1_ready", r1_ready, 1);
    chk("oob_before", oob_err, 0);
    @(posedge clk); #1;
    chk("oob_mem_we", mem_we, 0);
    chk("oob_set", oob_err, 1);
    chk("oob_hold_h", mem_h, 10'd11);
    @(negedge clk); r1_valid = 0;
    @(posedge clk); #1;
    chk("oob_sticky", oob_err, 1);

    // asynchronous reset mid-cycle
    @(negedge clk);
    r0_valid = 1; r0_h = 10'd9; r0_v = 9'd9; r0_data = 24'h999999;
    @(posedge clk); #1;
    chk("pre_rst_we", mem_we, 1);
    r0_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_h", mem_h, 0);
    chk("arst_mem_data", mem_data, 0);
    chk("arst_oob_err", oob_err, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    r0_valid = 1; r0_h = 10'd1; r0_v = 9'd1; r0_data = 24'h0000AA;
    r1_valid = 1; r1_h = 10'd2; r1_v = 9'd2; r1_data = 24'h0000BB;
    #1;
    chk("tie_after_rst_r0", r0_ready, 1);
    chk("tie_after_rst_r1", r1_ready, 0);
    @(negedge clk); r0_valid = 0; r1_valid = 0;

    // fill on 4x3 instance with r1 held pending
    @(negedge clk);
    s_fill_start = 1; s_fill_color = 24'h00FF00;
    s_r1_valid = 1; s_r1_h = 10'd2; s_r1_v = 9'd1; s_r1_data = 24'hABCDEF;
    #1;
    chk("fs_blocks_r1", s_r1_ready, 0);
    @(posedge clk); #1;
    chk("fill_busy_rise", s_fill_busy, 1);
    chk("fill_first_no_we", s_mem_we, 0);
    @(negedge clk); s_fill_start = 0; s_fill_color = 24'h0000FF;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("f%0d_we", k), s_mem_we, 1);
      chk($sformatf("f%0d_h", k), s_mem_h, k % 4);
      chk($sformatf("f%0d_v", k), s_mem_v, k / 4);
      chk($sformatf("f%0d_data", k), s_mem_data, 24'h00FF00);
      chk($sformatf("f%0d_done", k), s_fill_done, (k == 11));
      chk($sformatf("f%0d_busy", k), s_fill_busy, (k != 11));
      chk($sformatf("f%0d_r1_ready", k), s_r1_ready, (k == 11));
      @(negedge clk); s_fill_start = (k == 3);
    end
    @(posedge clk); #1;
    chk("after_fill_we", s_mem_we, 1);
    chk("after_fill_h", s_mem_h, 10'd2);
    chk("after_fill_v", s_mem_v, 9'd1);
    chk("after_fill_data", s_mem_data, 24'hABCDEF);
    chk("after_fill_done", s_fill_done, 0);
    chk("after_fill_busy", s_fill_busy, 0);
    @(negedge clk); s_r1_valid = 0;
    @(posedge clk); #1;
    chk("idle_we", s_mem_we, 0);

    // reset aborts a fill; restart uses new colour from (0,0)
    @(negedge clk); s_fill_start = 1; s_fill_color = 24'h111111;
    @(negedge clk); s_fill_start = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("a%0d_h", k), s_mem_h, k % 4);
    end
    @(negedge clk); rst = 1;
    #1;
    chk("abort_busy", s_fill_busy, 0);
    chk("abort_we", s_mem_we, 0);
    @(negedge clk); rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort%0d_done", k), s_fill_done, 0);
      chk($sformatf("abort%0d_we", k), s_mem_we, 0);
    end
    @(negedge clk); s_fill_start = 1; s_fill_color = 24'h222222;
    @(negedge clk); s_fill_start = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("g%0d_h", k), s_mem_h, k % 4);
      chk($sformatf("g%0d_v", k), s_mem_v, k / 4);
      chk($sformatf("g%0d_data", k), s_mem_data, 24'h222222);
      chk($sformatf("g%0d_done", k), s_fill_done, (k == 11));
    end
    @(posedge clk); #1;
    chk("g_end_we", s_mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
